// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
// UART transmitter that drains a show-ahead FIFO. Each frame is one start bit
// (0), DBIT data bits sent LSB first, and a stop bit (1) lasting SB_TICK
// oversampling ticks. Data and start bits last 16 ticks each, so a frame spans
// 16*(1+DBIT)+SB_TICK s_tick pulses.
//
// Parameters
//   DBIT     data bits per frame (>= 1)
//   SB_TICK  s_tick count of the stop bit (16/24/32 = 1/1.5/2 stop bits)
//
// Ports
//   clk          in   system clock, all state updates on its rising edge
//   reset        in   asynchronous, active-low reset
//   s_tick       in   one-clk pulse at 16x baud rate
//   empty        in   FIFO empty flag; rd_data is valid when empty=0
//   rd_data      in   FIFO head word (DBIT bits)
//   rd           out  one-clk pop strobe, only in IDLE with a non-empty FIFO
//   tx           out  serial line (registered, idle high)
//   tx_busy      out  high whenever the FSM is not in IDLE
//   tx_done_tick out  one-clk pulse on the last tick of the stop bit
// -----------------------------------------------------------------------------
module fifo_uart_tx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            empty,
    input  logic [DBIT-1:0] rd_data,
    output logic            rd,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);

    // Tick counter must reach both 15 (start/data bits) and SB_TICK-1 (stop bit).
    localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [SW-1:0] S_BIT_LAST  = SW'(15);
    localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t            r_state;
    logic   [SW-1:0]   r_s;
    logic   [NW-1:0]   r_n;
    logic   [DBIT-1:0] r_b;
    logic              r_tx;

    state_t            w_state_next;
    logic   [SW-1:0]   w_s_next;
    logic   [NW-1:0]   w_n_next;
    logic   [DBIT-1:0] w_b_next;
    logic              w_tx_next;
    logic              w_rd;
    logic              w_done;
    logic   [DBIT-1:0] w_b_shift;

    assign w_b_shift = r_b >> 1;

    // State, counters, shift register and the registered serial line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_b     <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_s     <= w_s_next;
            r_n     <= w_n_next;
            r_b     <= w_b_next;
            r_tx    <= w_tx_next;
        end
    end

    // Next-state logic. w_tx_next is the line level of the *next* cycle's
    // state, so tx changes on the same edge as the state and the start bit
    // appears the cycle right after the pop.
    always_comb begin
        w_state_next = r_state;
        w_s_next     = r_s;
        w_n_next     = r_n;
        w_b_next     = r_b;
        w_tx_next    = r_tx;
        w_rd         = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!empty) begin
                    // Pop and load; a coincident s_tick does not count.
                    w_rd         = 1'b1;
                    w_b_next     = rd_data;
                    w_s_next     = '0;
                    w_state_next = ST_START;
                    w_tx_next    = 1'b0;
                end else begin
                    w_tx_next    = 1'b1;
                end
            end
            ST_START: begin
                w_tx_next = 1'b0;
                if (s_tick) begin
                    if (r_s == S_BIT_LAST) begin
                        w_s_next     = '0;
                        w_n_next     = '0;
                        w_state_next = ST_DATA;
                        w_tx_next    = r_b[0];
                    end else begin
                        w_s_next     = r_s + SW'(1);
                    end
                end else begin
                    w_s_next = r_s;
                end
            end
            ST_DATA: begin
                w_tx_next = r_b[0];
                if (s_tick) begin
                    if (r_s == S_BIT_LAST) begin
                        w_s_next = '0;
                        w_b_next = w_b_shift;
                        if (r_n == N_LAST) begin
                            w_state_next = ST_STOP;
                            w_tx_next    = 1'b1;
                        end else begin
                            w_n_next     = r_n + NW'(1);
                            w_tx_next    = w_b_shift[0];
                        end
                    end else begin
                        w_s_next = r_s + SW'(1);
                    end
                end else begin
                    w_s_next = r_s;
                end
            end
            ST_STOP: begin
                w_tx_next = 1'b1;
                if (s_tick) begin
                    if (r_s == S_STOP_LAST) begin
                        w_state_next = ST_IDLE;
                        w_done       = 1'b1;
                    end else begin
                        w_s_next     = r_s + SW'(1);
                    end
                end else begin
                    w_s_next = r_s;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_tx_next    = 1'b1;
            end
        endcase
    end

    // The FSM sits in IDLE during reset, so the pop strobe is gated with
    // reset to stay low while reset is asserted even if the FIFO is non-empty.
    assign rd           = w_rd & reset;
    assign tx           = r_tx;
    assign tx_busy      = (r_state != ST_IDLE);
    assign tx_done_tick = w_done;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx
// Directed bench for fifo_uart_tx. Two instances share clk/reset/s_tick/rd_data:
// dut uses the default parameters, dut32 has SB_TICK=32. The bench plays the
// FIFO (a queue), logs the outputs every cycle, and checks the logs against
// hand-derived frame timing: with the pop in cycle P and a tick every D clocks
// (tick in the pop cycle), bit k (0=start, 1..8 data, 9 stop) starts in cycle
// P+1+16*D*k and tx_done_tick fires in cycle P+(144+SB_TICK)*D.
// -----------------------------------------------------------------------------
module tb_fifo_uart_tx;

    logic       clk     = 1'b0;
    logic       reset   = 1'b0;
    logic       s_tick  = 1'b0;
    logic       empty_a = 1'b1;
    logic       empty_b = 1'b1;
    logic [7:0] rd_data = 8'h00;

    logic rd_a, tx_a, busy_a, done_a;
    logic rd_b, tx_b, busy_b, done_b;

    always #5 clk = ~clk;

    fifo_uart_tx dut (
        .clk(clk), .reset(reset), .s_tick(s_tick), .empty(empty_a),
        .rd_data(rd_data), .rd(rd_a), .tx(tx_a), .tx_busy(busy_a),
        .tx_done_tick(done_a)
    );

    fifo_uart_tx #(.DBIT(8), .SB_TICK(32)) dut32 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .empty(empty_b),
        .rd_data(rd_data), .rd(rd_b), .tx(tx_b), .tx_busy(busy_b),
        .tx_done_tick(done_b)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] q[$];
    logic       tx_log   [0:1023];
    logic       rd_log   [0:1023];
    logic       done_log [0:1023];
    logic       busy_log [0:1023];
    int         rd_cnt;
    int         done_cnt;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Runs ncyc cycles starting just after a rising edge; acts as the FIFO.
    task automatic capture(input int ncyc, input bit use32, input int div, input bit toggle);
        logic e;
        rd_cnt   = 0;
        done_cnt = 0;
        for (int c = 0; c < ncyc; c++) begin
            e = (q.size() == 0);
            if (toggle && e && c >= 5 && c <= 150 && (c % 7) == 3) e = 1'b0;
            rd_data = (q.size() != 0) ? q[0] : 8'hFF;
            s_tick  = ((c % div) == 0);
            empty_a = use32 ? 1'b1 : e;
            empty_b = use32 ? e : 1'b1;
            #1;
            tx_log[c]   = use32 ? tx_b   : tx_a;
            rd_log[c]   = use32 ? rd_b   : rd_a;
            done_log[c] = use32 ? done_b : done_a;
            busy_log[c] = use32 ? busy_b : busy_a;
            if (rd_log[c])   rd_cnt++;
            if (done_log[c]) done_cnt++;
            @(posedge clk);
            #1;
            if (rd_log[c] && q.size() != 0) q.delete(0);
        end
        s_tick  = 1'b0;
        empty_a = 1'b1;
        empty_b = 1'b1;
    endtask

    task automatic check_frame(input string tag, input int pop, input logic [7:0] data,
                               input int div, input int sb);
        int bt;
        int c;
        logic expb;
        bt = 16 * div;
        chk_eq({tag, "_rd"},        32'(rd_log[pop]),     32'd1);
        chk_eq({tag, "_tx_at_pop"}, 32'(tx_log[pop]),     32'd1);
        chk_eq({tag, "_start_edge"},32'(tx_log[pop + 1]), 32'd0);
        chk_eq({tag, "_busy"},      32'(busy_log[pop + 1]), 32'd1);
        for (int k = 0; k <= 8; k++) begin
            c = pop + 1 + k * bt + bt / 2;
            if (k == 0) expb = 1'b0;
            else        expb = data[k - 1];
            chk_eq($sformatf("%s_bit%0d", tag, k), 32'(tx_log[c]), 32'(expb));
        end
        chk_eq({tag, "_stop"},
               32'(tx_log[pop + 1 + 9 * bt + (sb * div) / 2]), 32'd1);
        chk_eq({tag, "_done"},       32'(done_log[pop + (144 + sb) * div]),     32'd1);
        chk_eq({tag, "_done_early"}, 32'(done_log[pop + (144 + sb) * div - 1]), 32'd0);
    endtask

    initial begin
        int bad_tx;
        int bad_busy;

        // Reset held with a non-empty FIFO and ticking: nothing may move.
        empty_a = 1'b0;
        empty_b = 1'b0;
        rd_data = 8'hA5;
        s_tick  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_eq("rst_rd",   32'(rd_a),   32'd0);
        chk_eq("rst_tx",   32'(tx_a),   32'd1);
        chk_eq("rst_busy", 32'(busy_a), 32'd0);
        chk_eq("rst_done", 32'(done_a), 32'd0);
        chk_eq("rst_rd32", 32'(rd_b),   32'd0);
        chk_eq("rst_tx32", 32'(tx_b),   32'd1);
        empty_a = 1'b1;
        empty_b = 1'b1;
        s_tick  = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Empty FIFO for 500 clocks with ticks running.
        capture(500, 1'b0, 1, 1'b0);
        bad_tx = 0;
        bad_busy = 0;
        for (int c = 0; c < 500; c++) begin
            if (tx_log[c] !== 1'b1)   bad_tx++;
            if (busy_log[c] !== 1'b0) bad_busy++;
        end
        chk_eq("idle_rd_cnt",   32'(rd_cnt),   32'd0);
        chk_eq("idle_done_cnt", 32'(done_cnt), 32'd0);
        chk_eq("idle_tx_low",   32'(bad_tx),   32'd0);
        chk_eq("idle_busy",     32'(bad_busy), 32'd0);

        // Single byte 0xA5, tick every clock: done 160 cycles after the pop.
        q.push_back(8'hA5);
        capture(170, 1'b0, 1, 1'b0);
        check_frame("a5", 0, 8'hA5, 1, 16);
        chk_eq("a5_rd_cnt",   32'(rd_cnt),   32'd1);
        chk_eq("a5_done_cnt", 32'(done_cnt), 32'd1);
        chk_eq("a5_idle",     32'(busy_log[165]), 32'd0);

        // Back-to-back 0x00, 0xFF, 0x3C: pops at 0, 161, 322.
        q.push_back(8'h00);
        q.push_back(8'hFF);
        q.push_back(8'h3C);
        capture(490, 1'b0, 1, 1'b0);
        check_frame("b2b0", 0,   8'h00, 1, 16);
        check_frame("b2b1", 161, 8'hFF, 1, 16);
        check_frame("b2b2", 322, 8'h3C, 1, 16);
        chk_eq("b2b_gap1_busy", 32'(busy_log[161]), 32'd0);
        chk_eq("b2b_gap2_busy", 32'(busy_log[322]), 32'd0);
        chk_eq("b2b_rd_cnt",    32'(rd_cnt),   32'd3);
        chk_eq("b2b_done_cnt",  32'(done_cnt), 32'd3);

        // Slow tick (every 4 clocks), byte 0x81: 64 clocks per bit.
        q.push_back(8'h81);
        capture(660, 1'b0, 4, 1'b0);
        check_frame("slow", 0, 8'h81, 4, 16);
        chk_eq("slow_bit1_last",  32'(tx_log[128]), 32'd1);
        chk_eq("slow_bit2_first", 32'(tx_log[129]), 32'd0);
        chk_eq("slow_rd_cnt",   32'(rd_cnt),   32'd1);
        chk_eq("slow_done_cnt", 32'(done_cnt), 32'd1);

        // SB_TICK=32 instance, byte 0x0F, empty toggling mid-frame.
        q.push_back(8'h0F);
        capture(190, 1'b1, 1, 1'b1);
        check_frame("sb32", 0, 8'h0F, 1, 32);
        chk_eq("sb32_stop_late", 32'(tx_log[170]),  32'd1);
        chk_eq("sb32_busy_late", 32'(busy_log[176]), 32'd1);
        chk_eq("sb32_rd_cnt",    32'(rd_cnt),   32'd1);
        chk_eq("sb32_done_cnt",  32'(done_cnt), 32'd1);

        // Mid-frame reset during data bit 3 of 0x55 (cycles 65..80).
        q.push_back(8'h55);
        capture(70, 1'b0, 1, 1'b0);
        chk_eq("mrst_pop",     32'(rd_log[0]), 32'd1);
        chk_eq("mrst_tx_pre",  32'(tx_a),   32'd0);
        chk_eq("mrst_busy_pre",32'(busy_a), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk_eq("mrst_tx",   32'(tx_a),   32'd1);
        chk_eq("mrst_busy", 32'(busy_a), 32'd0);
        chk_eq("mrst_rd",   32'(rd_a),   32'd0);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
        capture(200, 1'b0, 1, 1'b0);
        bad_tx = 0;
        for (int c = 0; c < 200; c++) begin
            if (tx_log[c] !== 1'b1) bad_tx++;
        end
        chk_eq("mrst_after_rd",   32'(rd_cnt),   32'd0);
        chk_eq("mrst_after_done", 32'(done_cnt), 32'd0);
        chk_eq("mrst_after_tx",   32'(bad_tx),   32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
